// File: rtl/load_mem_unit_pkg.sv
// ---------------------------------------------------------------------------
// load_mem_unit_pkg
// Shared types and helpers for the load memory unit.
//   load_func_e     : RV32I load funct3 encodings (LB, LH, LW, LBU, LHU)
//   is_legal_funct3 : true for the five load encodings above
//   is_misaligned   : halfword on an odd byte, or word not on a word boundary
//   load_extend     : pick the byte/half at a byte offset and extend it
// ---------------------------------------------------------------------------
package load_mem_unit_pkg;

    typedef enum logic [2:0] {
        LD_B  = 3'b000,
        LD_H  = 3'b001,
        LD_W  = 3'b010,
        LD_BU = 3'b100,
        LD_HU = 3'b101
    } load_func_e;

    function automatic logic is_legal_funct3(input logic [2:0] funct3);
        case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            3'b001, 3'b101: return off[0];
            3'b010:         return (off != 2'b00);
            default:        return 1'b0;
        endcase
    endfunction

    // Little-endian: shifting the word right by 8*off brings the addressed
    // byte/half down to bit 0, then it is sign- or zero-extended.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input load_func_e  func);
        logic [31:0] shifted;
        shifted = word >> {off, 3'b000};
        case (func)
            LD_B:    return {{24{shifted[7]}}, shifted[7:0]};
            LD_BU:   return {24'b0, shifted[7:0]};
            LD_H:    return {{16{shifted[15]}}, shifted[15:0]};
            LD_HU:   return {16'b0, shifted[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/load_mem_unit_if.sv
// ---------------------------------------------------------------------------
// load_mem_unit_if
// Bundles the load-buffer request, BRAM read port and result/CDB signals.
//   slave  : the load memory unit's view
//   master : the surrounding pipeline / memory view
// Request : flush_in, req_valid_in, req_addr_in, req_rob_ix_in, req_funct3_in,
//           req_read_out (same-cycle acknowledge)
// BRAM    : mem_en_out, mem_addr_out, mem_data_in (fixed latency, no handshake)
// Result  : result_valid_out, result_data_out, result_rob_ix_out,
//           result_fault_out, result_ready_in
// ---------------------------------------------------------------------------
interface load_mem_unit_if #(
    parameter int unsigned MEM_DEPTH    = 1024,
    parameter int unsigned ROB_IX_WIDTH = 3
);
    localparam int unsigned AW = $clog2(MEM_DEPTH);

    logic                    flush_in;
    logic                    req_valid_in;
    logic signed [31:0]      req_addr_in;
    logic [ROB_IX_WIDTH-1:0] req_rob_ix_in;
    logic [2:0]              req_funct3_in;
    logic                    req_read_out;

    logic                    mem_en_out;
    logic [AW-1:0]           mem_addr_out;
    logic [31:0]             mem_data_in;

    logic                    result_valid_out;
    logic [31:0]             result_data_out;
    logic [ROB_IX_WIDTH-1:0] result_rob_ix_out;
    logic                    result_fault_out;
    logic                    result_ready_in;

    modport slave (
        input  flush_in, req_valid_in, req_addr_in, req_rob_ix_in, req_funct3_in,
        output req_read_out,
        output mem_en_out, mem_addr_out,
        input  mem_data_in,
        output result_valid_out, result_data_out, result_rob_ix_out, result_fault_out,
        input  result_ready_in
    );

    modport master (
        output flush_in, req_valid_in, req_addr_in, req_rob_ix_in, req_funct3_in,
        input  req_read_out,
        input  mem_en_out, mem_addr_out,
        output mem_data_in,
        input  result_valid_out, result_data_out, result_rob_ix_out, result_fault_out,
        output result_ready_in
    );

endinterface

// File: rtl/load_mem_unit_result_fifo.sv
// ---------------------------------------------------------------------------
// load_result_fifo
// Synchronous FIFO with occupancy count; any DEPTH (pointers wrap mod DEPTH).
// Push and pop in the same cycle are allowed even when full.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   clr_i           : synchronous clear (flush), same effect as reset
//   push_i/push_data_i : write request and data
//   pop_i           : remove head (ignored when empty)
//   valid_o         : FIFO not empty
//   head_data_o     : head entry, all-zero when empty
//   count_o         : number of stored entries
// ---------------------------------------------------------------------------
module load_result_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           head_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count_q alone decides which entries are visible.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign valid_o     = (count_q != '0);
    assign head_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o     = count_q;

endmodule

// File: rtl/load_mem_unit.sv
// ---------------------------------------------------------------------------
// load_mem_unit
// Memory-side responder for the load buffer. Accepts one load per cycle with
// a same-cycle acknowledge, reads a fixed-latency BRAM, aligns and extends the
// returned word, and queues results in order for the CDB.
//   clk_in : clock
//   rst_in : synchronous active-high reset
//   bus    : load_mem_unit_if.slave (request, BRAM port, result/CDB)
// Acceptance is credit based: a load is taken only if every load already in
// flight or queued still leaves a free result slot, so the metadata pipeline
// never stalls and no result is ever dropped under CDB backpressure.
// ---------------------------------------------------------------------------
module load_mem_unit
    import load_mem_unit_pkg::*;
#(
    parameter int unsigned MEM_DEPTH    = 1024,
    parameter int unsigned BRAM_LATENCY = 2,
    parameter int unsigned OUT_DEPTH    = 3,   // must be >= BRAM_LATENCY+1
    parameter int unsigned ROB_IX_WIDTH = 3
) (
    input logic            clk_in,
    input logic            rst_in,
    load_mem_unit_if.slave bus
);
    localparam int unsigned AW        = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_W     = $clog2(OUT_DEPTH + 1);
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_DEPTH);

    typedef struct packed {
        logic                    valid;
        logic [ROB_IX_WIDTH-1:0] rob_ix;
        load_func_e              func;
        logic [1:0]              off;
        logic                    fault;
    } meta_t;

    typedef struct packed {
        logic                    fault;
        logic [ROB_IX_WIDTH-1:0] rob_ix;
        logic [31:0]             data;
    } result_t;

    meta_t             pipe_q [BRAM_LATENCY];
    meta_t             pipe_d [BRAM_LATENCY];
    meta_t             tail;
    result_t           push_data;
    result_t           fifo_head;
    logic              fifo_valid;
    logic [CNT_W-1:0]  fifo_count;
    int unsigned       inflight;

    logic [31:0]       addr_u;
    logic [AW-1:0]     word;
    logic [1:0]        off;
    logic              req_fault;
    logic              credit_ok;
    logic              accept;

    // ---------------- request decode and credit ----------------
    assign addr_u = bus.req_addr_in;
    assign word   = addr_u[AW+1:2];
    assign off    = addr_u[1:0];

    // Negative addresses have bit 31 set; the unsigned compare would also
    // catch them, but both are kept so the intent reads directly.
    assign req_fault = addr_u[31]
                    || (addr_u >= MEM_BYTES)
                    || !is_legal_funct3(bus.req_funct3_in)
                    || is_misaligned(bus.req_funct3_in, off);

    always_comb begin
        inflight = 0;
        for (int i = 0; i < int'(BRAM_LATENCY); i++) begin
            inflight += {31'b0, pipe_q[i].valid};
        end
    end

    // Depends only on registered occupancy, never on result_ready_in, so
    // there is no combinational path back to the CDB arbiter.
    assign credit_ok = ({{(32-CNT_W){1'b0}}, fifo_count} + inflight) < OUT_DEPTH;
    assign accept    = bus.req_valid_in && !bus.flush_in && !rst_in && credit_ok;

    assign bus.req_read_out = accept;
    assign bus.mem_en_out   = accept && !req_fault;
    assign bus.mem_addr_out = bus.mem_en_out ? word : '0;

    // ---------------- metadata pipeline (mirrors BRAM latency) ----------------
    always_comb begin
        pipe_d[0] = '{valid:  accept,
                      rob_ix: bus.req_rob_ix_in,
                      func:   load_func_e'(bus.req_funct3_in),
                      off:    off,
                      fault:  req_fault};
        for (int i = 1; i < int'(BRAM_LATENCY); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || bus.flush_in) begin
            for (int i = 0; i < int'(BRAM_LATENCY); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
            for (int i = 0; i < int'(BRAM_LATENCY); i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    // The last stage lines up with mem_data_in; faulting loads never read
    // the BRAM, so whatever is on the data bus is replaced by zero.
    assign tail             = pipe_q[BRAM_LATENCY-1];
    assign push_data.fault  = tail.fault;
    assign push_data.rob_ix = tail.rob_ix;
    assign push_data.data   = tail.fault ? '0 : load_extend(bus.mem_data_in, tail.off, tail.func);

    // ---------------- result queue ----------------
    load_result_fifo #(
        .WIDTH ($bits(result_t)),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk_i       (clk_in),
        .rst_i       (rst_in),
        .clr_i       (bus.flush_in),
        .push_i      (tail.valid),
        .push_data_i (push_data),
        .pop_i       (bus.result_ready_in),
        .valid_o     (fifo_valid),
        .head_data_o (fifo_head),
        .count_o     (fifo_count)
    );

    // The FIFO zeroes its head when empty, so these are 0 with no result.
    assign bus.result_valid_out  = fifo_valid;
    assign bus.result_data_out   = fifo_head.data;
    assign bus.result_rob_ix_out = fifo_head.rob_ix;
    assign bus.result_fault_out  = fifo_head.fault;

endmodule

// File: tb/tb_load_mem_unit.sv
// ---------------------------------------------------------------------------
// tb_load_mem_unit
// Drives load_mem_unit with directed scenarios and randomized traffic. A
// behavioural model (queue of accepted loads, each visible 3 cycles after
// acceptance, credit = loads accepted but not yet popped) predicts every
// output on every cycle; directed scenarios also pin literal values.
// ---------------------------------------------------------------------------
module tb_load_mem_unit;

    localparam int unsigned DEPTH = 1024;

    logic clk_in = 1'b0;
    logic rst_in;

    always #5 clk_in = ~clk_in;

    load_mem_unit_if #(.MEM_DEPTH(DEPTH), .ROB_IX_WIDTH(3)) bus ();

    load_mem_unit #(
        .MEM_DEPTH    (DEPTH),
        .BRAM_LATENCY (2),
        .OUT_DEPTH    (3),
        .ROB_IX_WIDTH (3)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [31:0] mem [DEPTH];
    logic [31:0] bram_d1;

    typedef struct {
        int          ready_cyc;
        logic [31:0] data;
        logic [2:0]  rob;
        logic        fault;
    } exp_t;
    exp_t mq[$];

    typedef struct {
        logic [31:0] data;
        logic [2:0]  rob;
        logic        fault;
    } res_t;
    res_t got[$];

    logic last_mem_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic logic ref_fault(input logic [31:0] a, input logic [2:0] f3);
        int  sa;
        bit  legal;
        sa    = a;
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (sa < 0 || sa >= 4 * int'(DEPTH)) return 1'b1;
        if (!legal) return 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && (sa % 2 != 0)) return 1'b1;
        if (f3 == 3'd2 && (sa % 4 != 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_data(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] w, b, h;
        int          sh;
        if (ref_fault(a, f3)) return 32'd0;
        w  = mem[10'(a / 4)];
        sh = 8 * int'(a % 4);
        b  = (w >> sh) & 32'hFF;
        h  = (w >> sh) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128)   ? b - 32'd256   : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // ---------------- BRAM model: 2-cycle read latency ----------------
    always @(posedge clk_in) begin
        bram_d1         <= bus.mem_en_out ? mem[bus.mem_addr_out] : $urandom();
        bus.mem_data_in <= bram_d1;
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk_in) begin
        logic [31:0] a;
        logic [2:0]  f3;
        logic        exp_acc, exp_flt, exp_en, vis;
        logic [31:0] exp_maddr;
        a         = bus.req_addr_in;
        f3        = bus.req_funct3_in;
        exp_acc   = bus.req_valid_in && !bus.flush_in && !rst_in && (mq.size() < 3);
        exp_flt   = ref_fault(a, f3);
        exp_en    = exp_acc && !exp_flt;
        exp_maddr = exp_en ? (a / 4) : 32'd0;
        vis       = 1'b0;
        if (mq.size() > 0) vis = (mq[0].ready_cyc <= cyc);

        check("req_read", 32'(bus.req_read_out), 32'(exp_acc));
        check("mem_en", 32'(bus.mem_en_out), 32'(exp_en));
        check("mem_addr", 32'(bus.mem_addr_out), exp_maddr);
        check("res_valid", 32'(bus.result_valid_out), 32'(vis));
        if (vis) begin
            check("res_data", bus.result_data_out, mq[0].data);
            check("res_rob", 32'(bus.result_rob_ix_out), 32'(mq[0].rob));
            check("res_fault", 32'(bus.result_fault_out), 32'(mq[0].fault));
        end else begin
            check("idle_data", bus.result_data_out, 32'd0);
            check("idle_rob", 32'(bus.result_rob_ix_out), 32'd0);
            check("idle_fault", 32'(bus.result_fault_out), 32'd0);
        end

        if (rst_in || bus.flush_in) begin
            mq.delete();
        end else begin
            if (vis && bus.result_ready_in) void'(mq.pop_front());
            if (exp_acc) mq.push_back('{cyc + 3, ref_data(a, f3), bus.req_rob_ix_in, exp_flt});
        end
        cyc++;
    end

    // Collect popped results for the directed literal checks.
    always @(negedge clk_in) begin
        if (bus.result_valid_out === 1'b1 && bus.result_ready_in === 1'b1)
            got.push_back('{bus.result_data_out, bus.result_rob_ix_out, bus.result_fault_out});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_req(input bit v, input logic [31:0] a, input logic [2:0] rob, input logic [2:0] f3);
        bus.req_valid_in  = v;
        bus.req_addr_in   = a;
        bus.req_rob_ix_in = rob;
        bus.req_funct3_in = f3;
    endtask

    task automatic idle(input int n);
        set_req(0, 32'd0, 3'd0, 3'd0);
        repeat (n) tick();
    endtask

    // Present a load until acknowledged (bounded), then move to the next cycle.
    task automatic issue(input logic [31:0] a, input logic [2:0] rob, input logic [2:0] f3);
        bit ok;
        ok = 0;
        set_req(1, a, rob, f3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (bus.req_read_out) begin
                ok          = 1;
                last_mem_en = bus.mem_en_out;
                break;
            end
            tick();
        end
        if (!ok) check("issue_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic wait_results(input int n);
        for (int i = 0; i < 60 && got.size() < n; i++) tick();
        check("result_count", 32'(got.size()), 32'(n));
    endtask

    function automatic logic [31:0] rnd_addr();
        int k;
        k = $urandom_range(0, 99);
        if (k < 80) return 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(0, 3));
        if (k < 88) return 32'(4 * DEPTH + $urandom_range(0, 256));
        if (k < 94) return -32'($urandom_range(1, 256));
        return 32'(4 * DEPTH - 4 + $urandom_range(0, 7));
    endfunction

    function automatic logic [2:0] rnd_f3();
        logic [2:0] legal [5];
        legal = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        if ($urandom_range(0, 99) < 85) return legal[$urandom_range(0, 4)];
        return 3'($urandom_range(0, 7));
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = $urandom();
        mem[4]  = 32'h8081_F0F7;
        rst_in  = 1'b1;
        bus.flush_in        = 1'b0;
        bus.result_ready_in = 1'b1;
        set_req(0, 32'd0, 3'd0, 3'd0);

        repeat (3) tick();
        @(negedge clk_in);
        check("rst_valid", 32'(bus.result_valid_out), 32'd0);
        check("rst_read", 32'(bus.req_read_out), 32'd0);
        rst_in = 1'b0;
        idle(2);

        // LW 16 -> word 4, result three cycles after acceptance
        set_req(1, 32'd16, 3'd5, 3'b010);
        @(negedge clk_in);
        check("t1_accept", 32'(bus.req_read_out), 32'd1);
        check("t1_mem_addr", 32'(bus.mem_addr_out), 32'd4);
        tick();
        set_req(0, 32'd0, 3'd0, 3'd0);
        @(negedge clk_in);
        check("t1_n1_valid", 32'(bus.result_valid_out), 32'd0);
        tick();
        @(negedge clk_in);
        check("t1_n2_valid", 32'(bus.result_valid_out), 32'd0);
        tick();
        @(negedge clk_in);
        check("t1_n3_valid", 32'(bus.result_valid_out), 32'd1);
        check("t1_data", bus.result_data_out, 32'h8081_F0F7);
        check("t1_rob", 32'(bus.result_rob_ix_out), 32'd5);
        check("t1_fault", 32'(bus.result_fault_out), 32'd0);
        idle(3);

        // Extension on the same word
        got.delete();
        issue(32'd17, 3'd1, 3'b000);
        issue(32'd19, 3'd2, 3'b100);
        issue(32'd18, 3'd3, 3'b001);
        issue(32'd16, 3'd4, 3'b101);
        idle(0);
        wait_results(4);
        if (got.size() == 4) begin
            check("ext_lb",  got[0].data, 32'hFFFF_FFF0);
            check("ext_lbu", got[1].data, 32'h0000_0080);
            check("ext_lh",  got[2].data, 32'hFFFF_8081);
            check("ext_lhu", got[3].data, 32'h0000_F0F7);
            check("ext_order", {got[0].rob, got[1].rob, got[2].rob, got[3].rob}, 32'o1234);
        end
        idle(3);

        // Faults: misaligned, out of range, negative, illegal funct3
        got.delete();
        issue(32'd18, 3'd1, 3'b010);   check("f_lw18_en", 32'(last_mem_en), 32'd0);
        issue(32'd17, 3'd2, 3'b001);   check("f_lh17_en", 32'(last_mem_en), 32'd0);
        issue(32'd4096, 3'd3, 3'b010); check("f_4096_en", 32'(last_mem_en), 32'd0);
        issue(-32'sd4, 3'd4, 3'b010);  check("f_neg_en", 32'(last_mem_en), 32'd0);
        issue(32'd16, 3'd5, 3'b011);   check("f_f3_en", 32'(last_mem_en), 32'd0);
        idle(0);
        wait_results(5);
        foreach (got[i]) begin
            check("f_data", got[i].data, 32'd0);
            check("f_fault", 32'(got[i].fault), 32'd1);
            check("f_rob", 32'(got[i].rob), 32'(i + 1));
        end
        idle(3);

        // Backpressure: only three loads fit while the CDB is stalled
        begin
            int acc;
            acc = 0;
            got.delete();
            bus.result_ready_in = 1'b0;
            for (int i = 0; i < 5; i++) begin
                set_req(1, 32'(32 + 4 * i), 3'(i), 3'b010);
                @(negedge clk_in);
                if (bus.req_read_out) acc++;
                if (i == 4) check("bp_stalled", 32'(bus.req_read_out), 32'd0);
                tick();
            end
            check("bp_accepted", 32'(acc), 32'd3);
            set_req(1, 32'd64, 3'd6, 3'b010);
            bus.result_ready_in = 1'b1;
            @(negedge clk_in);
            check("bp_pop_cycle", 32'(bus.req_read_out), 32'd0);
            tick();
            @(negedge clk_in);
            check("bp_resume", 32'(bus.req_read_out), 32'd1);
            tick();
            idle(0);
            wait_results(4);
            if (got.size() == 4) begin
                check("bp_d0", got[0].data, mem[8]);
                check("bp_d1", got[1].data, mem[9]);
                check("bp_d2", got[2].data, mem[10]);
                check("bp_d3", got[3].data, mem[16]);
                check("bp_order", {got[0].rob, got[1].rob, got[2].rob, got[3].rob}, 32'o0126);
            end
            idle(3);
        end

        // Flush and reset with two loads in flight and one queued
        for (int pass = 0; pass < 2; pass++) begin
            bus.result_ready_in = 1'b0;
            for (int i = 0; i < 3; i++) begin
                set_req(1, 32'(4 * i), 3'(i), 3'b010);
                tick();
            end
            set_req(1, 32'd16, 3'd7, 3'b010);
            if (pass == 0) bus.flush_in = 1'b1;
            else           rst_in       = 1'b1;
            @(negedge clk_in);
            check("squash_no_accept", 32'(bus.req_read_out), 32'd0);
            tick();
            bus.flush_in        = 1'b0;
            rst_in              = 1'b0;
            bus.result_ready_in = 1'b1;
            set_req(0, 32'd0, 3'd0, 3'd0);
            for (int i = 0; i < 6; i++) begin
                @(negedge clk_in);
                check("squash_quiet", 32'(bus.result_valid_out), 32'd0);
                if (i == 0) begin
                    check("squash_data", bus.result_data_out, 32'd0);
                    check("squash_mem_en", 32'(bus.mem_en_out), 32'd0);
                end
                tick();
            end
            got.delete();
            issue(32'd16, 3'd3, 3'b010);
            idle(0);
            wait_results(1);
            if (got.size() == 1) begin
                check("squash_new_data", got[0].data, 32'h8081_F0F7);
                check("squash_new_rob", 32'(got[0].rob), 32'd3);
            end
            idle(2);
        end

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            set_req($urandom_range(0, 99) < 70, rnd_addr(), 3'($urandom_range(0, 7)), rnd_f3());
            bus.result_ready_in = ($urandom_range(0, 99) < 65);
            bus.flush_in        = ($urandom_range(0, 99) < 2);
            rst_in              = ($urandom_range(0, 199) == 0);
            tick();
        end
        bus.flush_in        = 1'b0;
        rst_in              = 1'b0;
        bus.result_ready_in = 1'b1;
        idle(10);
        check("drain_empty", 32'(bus.result_valid_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
